mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
Multi-cycle multiply sequencer for the EX stage. When the ALU control decodes a multiply (ALUCtrl 3'b100), this block captures the operands and runs an iterative radix-2 shift-add multiply. It stalls the pipeline until the low WIDTH bits of the product are ready, then presents them for EX-stage result selection. Non-multiply ALU operations bypass it with zero added latency.

Parameters:
WIDTH, 32, operand and result width; the multiply takes WIDTH iteration cycles.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
valid_i  input  1  EX stage holds a valid instruction
ALUCtrl_i  input  3  ALU control code from ALU control; 3'b100 = mul
flush_i  input  1  kill the EX instruction (branch/exception); aborts the multiply
data1_i  input  WIDTH  multiplicand (rs)
data2_i  input  WIDTH  multiplier (rt)
stall_o  output  1  freeze PC/IF/ID/EX pipeline registers
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse: result_o valid this cycle
result_o  output  WIDTH  low WIDTH bits of the product, registered

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE, counter=0, accumulator/operand registers=0, result_o=0. stall_o, busy_o and done_o read 0 while reset is held.
- start = valid_i && ALUCtrl_i==3'b100 && !flush_i, evaluated only in IDLE.
- States IDLE, RUN, DONE.
- IDLE:
  - On start: capture data1_i into mcand and data2_i into mplier; clear acc; counter=WIDTH; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If mplier[0], acc += mcand, mod 2**WIDTH.
  - mcand <<= 1; mplier >>= 1; counter -= 1.
  - Go to DONE when counter reaches 0, i.e. after exactly WIDTH RUN cycles.
  - Always fixed latency; no early termination.
- DONE:
  - result_o <= acc, latched on entry so it is visible in the DONE cycle.
  - done_o=1; return to IDLE unconditionally.
  - start is ignored in DONE, because the same mul is still in EX that cycle.
- stall_o (combinational) = (IDLE && start) || RUN. It is 0 in DONE, so the mul leaves EX at the end of the DONE cycle.
- Latency: start seen in cycle T; RUN in T+1..T+WIDTH; DONE in T+WIDTH+1.
  - stall_o is high for WIDTH+1 cycles (33 at default).
- Signedness: only the low WIDTH bits are produced, which are identical for signed and unsigned operands. No sign handling.
- result_o holds its value until the next DONE. It is not cleared by IDLE or flush.
- flush_i:
  - In RUN: go to IDLE next edge; stall_o drops in that same cycle (combinationally); no done_o; result_o unchanged.
  - In IDLE: suppresses start.
  - In DONE: done_o still pulses, since the result is harmless and the EX writeback is already killed by the flush.
- A non-mul ALUCtrl_i, or valid_i=0, never asserts stall_o.
- Operand changes on data*_i after capture have no effect.

Decomposition:
- Shared package/header:
  - ALU control codes: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_MUL=3'b100, ALU_SUB=3'b110.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The ALU control block uses the same constants.
- One sub-module, mul_shift_add_dp: holds mcand/mplier/acc and performs load/step under FSM control. The FSM, counter and stall logic stay in mul_seq_ctrl.

Test Plan:
- data1=3, data2=5, ALUCtrl=100, valid=1 -> stall_o high exactly 33 cycles; done_o pulses once in cycle T+33 with result_o=15; stall_o=0 in that cycle.
- data1=0xFFFFFFFF, data2=0xFFFFFFFF -> result_o=0x00000001; data1=0x80000000, data2=2 -> result_o=0x00000000 (wrap).
- ALUCtrl=010 (add), valid=1 for 10 cycles -> stall_o, busy_o and done_o stay 0; state remains IDLE.
- mul 7*9 started, flush_i pulsed at RUN cycle 10 -> stall_o=0 that cycle; IDLE next cycle; no done_o; result_o keeps its previous value.
- rst_i driven low at RUN cycle 5, asynchronously mid-cycle -> all outputs 0 immediately; after release a new mul 6*7 yields 42 with normal latency.
- Back-to-back mul 2*3 then 4*5 (second presented in the cycle after DONE) -> results 6 then 20; two separate 33-cycle stalls; exactly one idle cycle between them.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared constants for the EX-stage multiply sequencer.
// ALU control codes and the sequencer state encoding.
package mul_seq_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_mul(
    input logic [2:0] ctrl
  );
    return ctrl == ALU_MUL;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// EX-stage <-> multiply sequencer bundle.
// Signal suffixes are from the sequencer's point of view.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic             flush_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output valid_i,
    output ALUCtrl_i,
    output flush_i,
    output data1_i,
    output data2_i,
    input  stall_o,
    input  busy_o,
    input  done_o,
    input  result_o
  );

  modport slave (
    input  valid_i,
    input  ALUCtrl_i,
    input  flush_i,
    input  data1_i,
    input  data2_i,
    output stall_o,
    output busy_o,
    output done_o,
    output result_o
  );

endinterface

// File: rtl/mul_seq_ctrl_dp.sv
// Radix-2 shift-add multiply datapath.
// Loads operands, then one partial product per step.
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_nxt_o
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  assign acc_nxt_o = acc_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle multiply sequencer for the EX stage.
// Stalls the pipeline while the shift-add datapath iterates.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mul_seq_ctrl_if.slave bus
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             start;
  logic             load;
  logic             step;
  logic             stall;
  logic [WIDTH-1:0] acc_nxt;

  assign start = bus.valid_i
               && is_mul(bus.ALUCtrl_i)
               && !bus.flush_i;

  assign load = (state_q == S_IDLE) && start;
  assign step = (state_q == S_RUN);

  // Gated by reset so a mul held in EX
  // cannot raise stall while reset is low.
  always_comb begin
    stall = 1'b0;
    if (rst_i) begin
      stall = load || (step && !bus.flush_i);
    end
  end

  mul_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .step_i    (step),
    .mcand_i   (bus.data1_i),
    .mplier_i  (bus.data2_i),
    .acc_nxt_o (acc_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            // Last iteration: latch the final sum
            // so it is visible in the DONE cycle.
            if (cnt_q == CNT_W'(1)) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= acc_nxt;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_o  = stall;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule
